// File: rtl/sif_fifo_complex_half_fp.sv
// rtl/sif_fifo_complex_half_fp.sv - elastic FWFT FIFO for complex half-FP sample pairs
//
// Sits behind the complex half-FP add/sub stage and absorbs its S stream so
// the adder keeps running while the next butterfly stage or write-back stalls.
// Each entry holds one real word and one imaginary word, stored and emitted
// together. Data bits pass through untouched (NaN/Inf patterns included).
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   in_vld        in   upstream valid (adder S_vld)
//   in_real_dat   in   real word pushed with in_vld
//   in_img_dat    in   imaginary word pushed with in_vld
//   in_rdy        out  FIFO can accept (adder S_rdy); registered state only
//   out_vld       out  head entry valid
//   out_real_dat  out  head real word (first-word-fall-through)
//   out_img_dat   out  head imaginary word (first-word-fall-through)
//   out_rdy       in   downstream accepts
//   count         out  occupancy 0..DEPTH
//   almost_full   out  count >= AFULL_LVL
//
// Build option:
//   SIF_FIFO_CPLX_BYPASS_EN  when defined, an empty FIFO forwards in_* to
//                            out_* combinationally; a word taken on that same
//                            cycle is never written to storage.

module sif_fifo_complex_half_fp #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [WIDTH-1:0]         in_real_dat,
    input  logic [WIDTH-1:0]         in_img_dat,
    output logic                     in_rdy,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_real_dat,
    output logic [WIDTH-1:0]         out_img_dat,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LVL);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    // Storage: real and imag halves share one write enable and one index,
    // so a pair can never be split across entries.
    logic [WIDTH-1:0] mem_real [DEPTH];
    logic [WIDTH-1:0] mem_img  [DEPTH];

    // Pointers carry a wrap bit above the index bits.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    logic          fifo_vld;
    logic          push;
    logic          pop;
    logic [WIDTH-1:0] head_real;
    logic [WIDTH-1:0] head_img;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Flow control comes from the count register only, so in_rdy has no
    // combinational dependence on out_rdy. A full FIFO popping this cycle
    // therefore refuses the push and reopens on the following cycle.
    assign fifo_vld    = (count != '0);
    assign in_rdy      = (count != DEPTH_C);
    assign almost_full = (count >= AFULL_C);

    assign head_real = mem_real[rd_idx];
    assign head_img  = mem_img[rd_idx];

`ifdef SIF_FIFO_CPLX_BYPASS_EN
    logic bypass;

    // Empty with a word arriving: present it immediately. If the consumer
    // takes it now it never touches storage; otherwise it is pushed as usual.
    assign bypass       = ~fifo_vld & in_vld;
    assign out_vld      = fifo_vld | bypass;
    assign out_real_dat = bypass ? in_real_dat : head_real;
    assign out_img_dat  = bypass ? in_img_dat  : head_img;
    assign push         = in_vld & in_rdy & ~(bypass & out_rdy);
    assign pop          = fifo_vld & out_rdy;
`else
    assign out_vld      = fifo_vld;
    assign out_real_dat = head_real;
    assign out_img_dat  = head_img;
    assign push         = in_vld & in_rdy;
    assign pop          = fifo_vld & out_rdy;
`endif

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_C;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_C;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // Entry 0 is cleared on reset so the head reads as zero straight out of
    // reset; the remaining entries are always written before they are read.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_real[0] <= '0;
            mem_img[0]  <= '0;
        end else if (push) begin
            mem_real[wr_idx] <= in_real_dat;
            mem_img[wr_idx]  <= in_img_dat;
        end
    end

endmodule

// File: tb/tb_sif_fifo_complex_half_fp.sv
// tb/tb_sif_fifo_complex_half_fp.sv - directed self-checking bench for sif_fifo_complex_half_fp

module tb_sif_fifo_complex_half_fp;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic [15:0] in_real_dat;
    logic [15:0] in_img_dat;
    logic        in_rdy;
    logic        out_vld;
    logic [15:0] out_real_dat;
    logic [15:0] out_img_dat;
    logic        out_rdy;
    logic [3:0]  count;
    logic        almost_full;

    int errors = 0;
    int checks = 0;

    logic [31:0] pairs [3];
    logic [31:0] fill  [8];
    logic [31:0] stream_val;

    sif_fifo_complex_half_fp #(
        .WIDTH(16),
        .DEPTH(8),
        .AFULL_LVL(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_vld(in_vld),
        .in_real_dat(in_real_dat),
        .in_img_dat(in_img_dat),
        .in_rdy(in_rdy),
        .out_vld(out_vld),
        .out_real_dat(out_real_dat),
        .out_img_dat(out_img_dat),
        .out_rdy(out_rdy),
        .count(count),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pairs[0] = 32'h3C00_0000;
        pairs[1] = 32'h4000_BC00;
        pairs[2] = 32'hC200_4200;
        for (int i = 0; i < 8; i++) fill[i] = 32'h1000_2000 + 32'(i) * 32'h0001_0001;

        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        {in_real_dat, in_img_dat} = 32'h0;

        // reset state
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_dat", {out_real_dat, out_img_dat}, 32'h0);

        // push 3 pairs while stalled
        in_vld = 1'b1;
        {in_real_dat, in_img_dat} = pairs[0];
        #1;
        chk("empty_push_no_vld", 32'(out_vld), 32'd0);
        for (int i = 0; i < 3; i++) begin
            {in_real_dat, in_img_dat} = pairs[i];
            cyc();
            chk("push3_count", 32'(count), 32'(i + 1));
            chk("push3_head_hold", {out_real_dat, out_img_dat}, pairs[0]);
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("drain3_vld", 32'(out_vld), 32'd1);
            chk("drain3_dat", {out_real_dat, out_img_dat}, pairs[i]);
            cyc();
            chk("drain3_count", 32'(count), 32'(2 - i));
        end
        chk("drain3_empty", 32'(out_vld), 32'd0);
        out_rdy = 1'b0;

        // fill to full
        in_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {in_real_dat, in_img_dat} = fill[i];
            cyc();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            chk("fill_in_rdy", 32'(in_rdy), (i + 1 == 8) ? 32'd0 : 32'd1);
        end
        {in_real_dat, in_img_dat} = 32'h7BFF_7BFF;
        cyc();
        chk("full_hold_count", 32'(count), 32'd8);
        chk("full_hold_head", {out_real_dat, out_img_dat}, fill[0]);

        // full with push and pop requested: only the pop happens
        out_rdy = 1'b1;
        cyc();
        chk("full_pop_count", 32'(count), 32'd7);
        chk("full_pop_in_rdy", 32'(in_rdy), 32'd1);
        chk("full_pop_head", {out_real_dat, out_img_dat}, fill[1]);
        cyc();
        chk("pushpop7_count", 32'(count), 32'd7);
        chk("pushpop7_head", {out_real_dat, out_img_dat}, fill[2]);
        in_vld = 1'b0;
        for (int i = 2; i < 8; i++) begin
            chk("drain_fill_dat", {out_real_dat, out_img_dat}, fill[i]);
            cyc();
        end
        chk("drain_ninth_dat", {out_real_dat, out_img_dat}, 32'h7BFF_7BFF);
        chk("drain_ninth_count", 32'(count), 32'd1);
        cyc();
        chk("drain_done_count", 32'(count), 32'd0);
        chk("drain_done_vld", 32'(out_vld), 32'd0);

        // sustained streaming, 20 pairs
        in_vld = 1'b1;
        out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            stream_val = 32'h5000_9000 + 32'(k) * 32'h0003_0005;
            {in_real_dat, in_img_dat} = stream_val;
            cyc();
            chk("stream_vld", 32'(out_vld), 32'd1);
            chk("stream_dat", {out_real_dat, out_img_dat}, stream_val);
            chk("stream_count", 32'(count), 32'd1);
        end
        in_vld = 1'b0;
        cyc();
        chk("stream_end_count", 32'(count), 32'd0);
        out_rdy = 1'b0;

        // reset mid-operation
        in_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            {in_real_dat, in_img_dat} = fill[i] ^ 32'hFFFF_FFFF;
            cyc();
        end
        in_vld = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("mid_rst_dat", {out_real_dat, out_img_dat}, 32'h0);
        in_vld = 1'b1;
        {in_real_dat, in_img_dat} = 32'h3555_D555;
        cyc();
        in_vld = 1'b0;
        chk("post_rst_head", {out_real_dat, out_img_dat}, 32'h3555_D555);
        chk("post_rst_count", 32'(count), 32'd1);
        out_rdy = 1'b1;
        cyc();
        chk("post_rst_drain", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
